// File: rtl/wshb_fb_pkg.sv
// Shared types and constants for the Wishbone frame-buffer slave.
// Holds the cycle-type and burst-type encodings, the FSM state type and
// the bus data width used by the slave and its RAM.
package wshb_fb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    CtiClassic = 3'b000,
    CtiIncr    = 3'b010,
    CtiEob     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BteLinear = 2'b00,
    BteWrap4  = 2'b01,
    BteWrap8  = 2'b10,
    BteWrap16 = 2'b11
  } bte_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StAck   = 2'd1;
  localparam state_t StBurst = 2'd2;
  localparam state_t StErr   = 2'd3;

endpackage

// File: rtl/wshb_fb_ram.sv
// Single-port synchronous frame-buffer RAM, Depth x 32 bits.
// Ports:
//   clk_i   - clock
//   addr_i  - word address (shared by read and write)
//   we_i    - write enable, qualified per byte by be_i
//   be_i    - byte enables, be_i[i] covers wdata_i[8i+7:8i]
//   wdata_i - write data
//   rdata_o - read data, one cycle after addr_i (old data on a same-address write)
// Contents are never reset.
module wshb_fb_ram
  import wshb_fb_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic              clk_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wshb_fb_slave.sv
// Wishbone B4 slave exposing a HDISP x VDISP frame buffer, one pixel per 32-bit word.
// Ports:
//   wshb_clk, wshb_rst   - clock, synchronous active-high reset
//   cyc, stb, we         - bus cycle, strobe, write select
//   adr                  - byte address, word index = adr[31:2]
//   dat_ms, sel          - write data and byte enables
//   cti, bte             - cycle type / burst type (bte treated as linear)
//   dat_sm, ack, err     - read data, registered acknowledge, registered error
// Build option: define WSHB_FB_BURST_EN to compile in incrementing-burst support;
// without it every transfer is classic and cti is ignored.
module wshb_fb_slave
  import wshb_fb_pkg::*;
#(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err
);

  localparam int unsigned NWORDS = HDISP * VDISP;
  localparam int unsigned AddrW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  // One extra bit so the pointer can represent NWORDS itself.
  localparam int unsigned PtrW   = AddrW + 1;

  state_t           state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             xfer;
  logic [29:0]      idx;
  logic             in_range;
  logic [AddrW-1:0] ram_addr;
  logic             ram_we;
  logic [31:0]      ram_rdata;

  assign xfer     = cyc & stb;
  assign idx      = adr[31:2];
  assign in_range = {2'b00, idx} < NWORDS;

`ifdef WSHB_FB_BURST_EN
  localparam logic [PtrW-1:0] EndPtr = PtrW'(NWORDS);
  logic [PtrW-1:0] ptr_inc;
  logic            more;

  assign ptr_inc = ptr_q + PtrW'(1);
  // Master signals another beat follows the current one.
  assign more    = xfer & (cti == CTI_INCR);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ram_addr = ptr_q[AddrW-1:0];
    ram_we   = 1'b0;
    case (state_q)
      StIdle: begin
        ram_addr = idx[AddrW-1:0];
        if (xfer) begin
          if (in_range) begin
            ptr_d   = idx[PtrW-1:0];
            state_d = StAck;
          end else begin
            state_d = StErr;
          end
        end
      end
`ifdef WSHB_FB_BURST_EN
      StAck, StBurst: begin
`else
      StAck: begin
`endif
        ram_we  = xfer & we;
        state_d = StIdle;
`ifdef WSHB_FB_BURST_EN
        if (more) begin
          if (ptr_inc >= EndPtr) begin
            state_d = StErr;
          end else begin
            state_d = StBurst;
            ptr_d   = ptr_inc;
            // Prefetch the next word unless the port is busy with this beat's write.
            if (!we) begin
              ram_addr = ptr_inc[AddrW-1:0];
            end
          end
        end
`endif
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (wshb_rst) begin
      ram_we = 1'b0;
    end
  end

  assign ack_d = (state_d == StAck) || (state_d == StBurst);
  assign err_d = (state_d == StErr);

  always_ff @(posedge wshb_clk) begin
    if (wshb_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  wshb_fb_ram #(
    .Depth (NWORDS),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (wshb_clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (sel),
    .wdata_i (dat_ms),
    .rdata_o (ram_rdata)
  );

  assign ack    = ack_q;
  assign err    = err_q;
  assign dat_sm = ack_q ? ram_rdata : '0;

  logic unused_bits;
  assign unused_bits = ^{bte, adr[1:0], cti, ptr_q};

endmodule

// File: tb/tb_wshb_fb_slave.sv
module tb_wshb_fb_slave;

  localparam int unsigned NW = 8;

  logic        wshb_clk = 1'b0;
  logic        wshb_rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms, dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [NW];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [11];

  wshb_fb_slave #(
    .HDISP (4),
    .VDISP (2)
  ) dut (
    .wshb_clk (wshb_clk),
    .wshb_rst (wshb_rst),
    .cyc      (cyc),
    .stb      (stb),
    .we       (we),
    .adr      (adr),
    .dat_ms   (dat_ms),
    .sel      (sel),
    .cti      (cti),
    .bte      (bte),
    .dat_sm   (dat_sm),
    .ack      (ack),
    .err      (err)
  );

  always #5 wshb_clk = ~wshb_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wshb_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  task automatic drive_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  // One classic transfer: strobe, expect response next cycle, then an idle cycle.
  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] ct, input logic e_ack,
                         input logic e_err, input logic [31:0] e_dat, input string nm);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s; cti = ct;
    tick();
    chk({nm, "_ack"}, 32'(ack), 32'(e_ack));
    chk({nm, "_err"}, 32'(err), 32'(e_err));
    if (e_ack && !w) chk({nm, "_dat"}, dat_sm, e_dat);
    if (e_err) chk({nm, "_dat0"}, dat_sm, 32'h0);
    if (e_ack && w) ref_mem[a[4:2]] = merge(ref_mem[a[4:2]], d, s);
    tick();
    drive_idle();
    chk({nm, "_idle"}, 32'({ack, err}), 32'h0);
  endtask

  // Linear burst of n beats from word 'start'; last beat carries end-of-burst.
  task automatic burst(input logic w, input int unsigned start, input int unsigned n,
                       input logic [3:0] s, input string nm);
    bit done;
    int unsigned wi;
    done = 0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s;
    adr = 32'(start << 2);
    cti = (n == 1) ? 3'b111 : 3'b010;
    dat_ms = $urandom;
    for (int unsigned b = 0; b < n && !done; b++) begin
      tick();
      wi = start + b;
      adr = 32'(wi << 2);
      cti = (b == n - 1) ? 3'b111 : 3'b010;
      if (b > 0) dat_ms = $urandom;
      if (wi >= NW) begin
        chk({nm, "_eack"}, 32'(ack), 32'h0);
        chk({nm, "_err"}, 32'(err), 32'h1);
        chk({nm, "_edat"}, dat_sm, 32'h0);
        done = 1;
      end else begin
        chk({nm, "_ack"}, 32'({ack, err}), 32'h2);
        if (!w) chk({nm, "_dat"}, dat_sm, ref_mem[wi]);
        else ref_mem[wi] = merge(ref_mem[wi], dat_ms, s);
      end
    end
    tick();
    drive_idle();
    chk({nm, "_idle"}, 32'({ack, err}), 32'h0);
  endtask

  initial begin
    int unsigned idx;
    logic [31:0] a;
    logic [31:0] d;
    logic w;

    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hBABE_CAFE, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 1'b1, 1'b0, 32'hBABE_CAFE};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h0000_FFFF, 4'h3, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 1'b1, 1'b0, 32'hBABE_FFFF};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0024, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_001F, 32'h1234_5678, 4'hC, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0,         4'hF, 1'b1, 1'b0, 32'h1234_0007};
    vecs[8]  = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0005, 32'h0,         4'hF, 1'b1, 1'b0, 32'hC0BB_00DD};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};

    wshb_rst = 1'b1; drive_idle(); adr = '0; dat_ms = '0; sel = '0; bte = 2'b00;
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dat", dat_sm, 32'h0);
    wshb_rst = 1'b0;

    for (int i = 0; i < int'(NW); i++) begin
      classic(1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 4'hF, 3'b000, 1'b1, 1'b0, 32'h0,
              $sformatf("init%0d", i));
    end

    for (int i = 0; i < 11; i++) begin
      classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 3'b000, vecs[i].exp_ack,
              vecs[i].exp_err, vecs[i].exp_dat, $sformatf("vec%0d", i));
    end

    // Reset during the ack cycle of a write must suppress the write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC; dat_ms = 32'hDEAD_BEEF; sel = 4'hF;
    cti = 3'b000;
    tick();
    chk("rwr_ack", 32'(ack), 32'h1);
    wshb_rst = 1'b1;
    tick();
    chk("rwr_ack0", 32'({ack, err}), 32'h0);
    wshb_rst = 1'b0; drive_idle();
    tick();
    classic(1'b0, 32'hC, 32'h0, 4'hF, 3'b000, 1'b1, 1'b0, ref_mem[3], "rwr_rd");

`ifdef WSHB_FB_BURST_EN
    burst(1'b0, 0, 4, 4'hF, "b_rd4");
    burst(1'b0, 6, 4, 4'hF, "b_edge");
    burst(1'b1, 4, 3, 4'hF, "b_wr3");
    burst(1'b0, 3, 4, 4'hF, "b_rdbk");

    // Reset on the second beat of a burst write: word 2 keeps its old value.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dat_ms = 32'h1111_2222; sel = 4'hF;
    cti = 3'b010;
    tick();
    chk("brst_b1", 32'(ack), 32'h1);
    ref_mem[1] = 32'h1111_2222;
    tick();
    adr = 32'h8; dat_ms = 32'h3333_4444; wshb_rst = 1'b1;
    chk("brst_b2", 32'(ack), 32'h1);
    tick();
    chk("brst_ack0", 32'({ack, err}), 32'h0);
    chk("brst_dat0", dat_sm, 32'h0);
    wshb_rst = 1'b0; drive_idle();
    tick();
    classic(1'b0, 32'h8, 32'h0, 4'hF, 3'b000, 1'b1, 1'b0, ref_mem[2], "brst_w2");
    classic(1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 1'b1, 1'b0, ref_mem[1], "brst_w1");
`else
    // cti held at incrementing for back-to-back transfers: still classic.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF; cti = 3'b010;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("nb_ack%0d", t), 32'(ack), 32'h1);
      chk($sformatf("nb_dat%0d", t), dat_sm, ref_mem[t]);
      tick();
      chk($sformatf("nb_gap%0d", t), 32'(ack), 32'h0);
      if (t < 2) adr = 32'((t + 1) * 4);
      else drive_idle();
    end
    tick();
`endif

    for (int r = 0; r < 40; r++) begin
`ifdef WSHB_FB_BURST_EN
      if ($urandom_range(0, 1) == 1) begin
        burst(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(1, 4),
              4'($urandom_range(0, 15)), $sformatf("rb%0d", r));
        continue;
      end
`endif
      idx = $urandom_range(0, 9);
      a = 32'(idx << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
`ifdef WSHB_FB_BURST_EN
      classic(w, a, d, 4'($urandom_range(0, 15)), 3'b000, idx < NW, idx >= NW,
              (idx < NW) ? ref_mem[idx[2:0]] : 32'h0, $sformatf("rc%0d", r));
`else
      classic(w, a, d, 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000,
              idx < NW, idx >= NW, (idx < NW) ? ref_mem[idx[2:0]] : 32'h0,
              $sformatf("rc%0d", r));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
